voice_alloc: RTL

- Sits directly upstream of the synth voice engine, between the MIDI event decoder and the synth control port.
- Maps each MIDI event (note on, note off, poly key pressure, pitch wheel) onto a voice slot address.
- Drives the synth's one-cycle strobes plus note/velocity/channel/addr.
- Tracks voice occupancy and frees a slot when the synth reports that the voice has reached BLANK (the synth's data_valid/data pair).

---
 rtl/synth_pkg.sv | 28 ++
 rtl/voice_alloc_if.sv | 35 +++
 rtl/voice_table.sv | 83 ++++++++
 rtl/voice_alloc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared encodings for the voice allocator and the synth voice engine.
package synth_pkg;

    // Sound memory depth shared with the synth's MAX_SND_MEM.
    localparam int unsigned NUM_VOICES_DEF = 256;

    typedef enum logic [1:0] {
        EV_PRESS    = 2'd0,
        EV_RELEASE  = 2'd1,
        EV_KEYPRESS = 2'd2,
        EV_WHEEL    = 2'd3
    } ev_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StIssue,
        StStrobe,
        StHold
    } alloc_state_e;

    typedef logic [10:0] voice_key_t;

    function automatic voice_key_t make_key(input logic [3:0] ch, input logic [6:0] nt);
        return {ch, nt};
    endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// Event, free and synth-control bundle between decoder, allocator and synth.
interface voice_alloc_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              ev_valid;
    logic              ev_ready;
    logic [1:0]        ev_type;
    logic [3:0]        ev_channel;
    logic [6:0]        ev_note;
    logic [6:0]        ev_velocity;
    logic              free_valid;
    logic [ADDR_W-1:0] free_addr;
    logic              note_pressed;
    logic              note_released;
    logic              note_keypress;
    logic              pitch_wheel;
    logic [6:0]        note;
    logic [6:0]        velocity;
    logic [3:0]        channel;
    logic [ADDR_W-1:0] addr;
    logic              drop;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output ev_valid, ev_type, ev_channel, ev_note, ev_velocity, free_valid, free_addr,
        input  ev_ready, note_pressed, note_released, note_keypress, pitch_wheel,
               note, velocity, channel, addr, drop, busy_count
    );

    modport slave (
        input  ev_valid, ev_type, ev_channel, ev_note, ev_velocity, free_valid, free_addr,
        output ev_ready, note_pressed, note_released, note_keypress, pitch_wheel,
               note, velocity, channel, addr, drop, busy_count
    );
endinterface

// File: rtl/voice_table.sv
// Voice slot storage: one read index, a commit port and a free port, plus occupancy count.
module voice_table
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic              rd_busy_o,
    output logic              rd_released_o,
    output voice_key_t        rd_key_o,
    input  logic              cm_en_i,
    input  logic              cm_press_i,
    input  logic [ADDR_W-1:0] cm_idx_i,
    input  voice_key_t        cm_key_i,
    input  logic              fr_en_i,
    input  logic [ADDR_W-1:0] fr_idx_i,
    output logic [ADDR_W:0]   busy_count_o
);
    localparam logic [ADDR_W:0] CntMax = (ADDR_W + 1)'(NUM_VOICES);
    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    logic [NUM_VOICES-1:0] busy_q, rel_q;
    voice_key_t            key_q [NUM_VOICES];
    logic [ADDR_W:0]       count_q, count_d;
    logic                  cm_busy, fr_busy, fr_eff, inc;

    always_comb begin
        rd_busy_o     = 1'b0;
        rd_released_o = 1'b0;
        rd_key_o      = '0;
        cm_busy       = 1'b0;
        fr_busy       = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rd_idx_i == ADDR_W'(i)) begin
                rd_busy_o     = busy_q[i];
                rd_released_o = rel_q[i];
                rd_key_o      = key_q[i];
            end
            if (cm_idx_i == ADDR_W'(i)) cm_busy = busy_q[i];
            if (fr_idx_i == ADDR_W'(i)) fr_busy = busy_q[i];
        end
        // An out-of-range free index never matches a slot, so fr_busy stays low.
        fr_eff = fr_en_i && fr_busy && !(cm_en_i && cm_idx_i == fr_idx_i);
        inc    = cm_en_i && cm_press_i && !cm_busy;
        count_d = count_q;
        if (inc && !fr_eff && count_q != CntMax) begin
            count_d = count_q + CntOne;
        end else if (fr_eff && !inc && count_q != '0) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            rel_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) key_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (cm_en_i && cm_idx_i == ADDR_W'(i)) begin
                    if (cm_press_i) begin
                        busy_q[i] <= 1'b1;
                        rel_q[i]  <= 1'b0;
                        key_q[i]  <= cm_key_i;
                    end else begin
                        rel_q[i] <= 1'b1;
                    end
                end else if (fr_en_i && fr_idx_i == ADDR_W'(i)) begin
                    busy_q[i] <= 1'b0;
                    rel_q[i]  <= 1'b0;
                end
            end
            count_q <= count_d;
        end
    end

    assign busy_count_o = count_q;

endmodule

// File: rtl/voice_alloc.sv
// Maps MIDI events onto voice slots and drives the synth's addr/field/strobe interface.
module voice_alloc
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned ADDR_SETUP = 2
) (
    input logic          clk96,
    input logic          rst,
    voice_alloc_if.slave bus
);
    localparam int unsigned       SetupW  = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_VOICES - 1);
    localparam logic [ADDR_W-1:0] IdxOne  = ADDR_W'(1);

    alloc_state_e      state_q, state_d;
    ev_type_e          type_q, type_d;
    logic [3:0]        ev_ch_q, ev_ch_d;
    logic [6:0]        ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
    logic [ADDR_W-1:0] scan_q, scan_d, steal_q, steal_d;
    logic              hit_q, hit_d, free_q, free_d;
    logic [ADDR_W-1:0] hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
    logic [SetupW-1:0] setup_q, setup_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        note_q, note_d, vel_q, vel_d;
    logic [3:0]        chan_q, chan_d;
    logic              drop_q, drop_d;

    logic              rd_busy, rd_rel, key_match, cm_en, go_issue;
    voice_key_t        rd_key;
    logic [ADDR_W-1:0] slot;

    voice_table #(
        .NUM_VOICES(NUM_VOICES),
        .ADDR_W    (ADDR_W)
    ) u_table (
        .clk_i        (clk96),
        .rst_i        (rst),
        .rd_idx_i     (scan_q),
        .rd_busy_o    (rd_busy),
        .rd_released_o(rd_rel),
        .rd_key_o     (rd_key),
        .cm_en_i      (cm_en),
        .cm_press_i   (type_q == EV_PRESS),
        .cm_idx_i     (addr_q),
        .cm_key_i     (make_key(ev_ch_q, ev_note_q)),
        .fr_en_i      (bus.free_valid),
        .fr_idx_i     (bus.free_addr),
        .busy_count_o (bus.busy_count)
    );

    assign key_match = (rd_key == make_key(ev_ch_q, ev_note_q));

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        ev_ch_d    = ev_ch_q;
        ev_note_d  = ev_note_q;
        ev_vel_d   = ev_vel_q;
        scan_d     = scan_q;
        steal_d    = steal_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        free_d     = free_q;
        free_idx_d = free_idx_q;
        setup_d    = setup_q;
        addr_d     = addr_q;
        note_d     = note_q;
        vel_d      = vel_q;
        chan_d     = chan_q;
        drop_d     = 1'b0;
        cm_en      = 1'b0;
        go_issue   = 1'b0;
        slot       = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.ev_valid) begin
                    type_d    = ev_type_e'(bus.ev_type);
                    ev_ch_d   = bus.ev_channel;
                    ev_note_d = bus.ev_note;
                    ev_vel_d  = bus.ev_velocity;
                    scan_d    = '0;
                    hit_d     = 1'b0;
                    free_d    = 1'b0;
                    setup_d   = '0;
                    if (ev_type_e'(bus.ev_type) == EV_WHEEL) begin
                        state_d = StIssue;
                        addr_d  = '0;
                        note_d  = bus.ev_note;
                        vel_d   = bus.ev_velocity;
                        chan_d  = bus.ev_channel;
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                scan_d = scan_q + IdxOne;
                if (type_q == EV_PRESS) begin
                    if (!hit_q && rd_busy && key_match) begin
                        hit_d     = 1'b1;
                        hit_idx_d = scan_q;
                    end
                    if (!free_q && !rd_busy) begin
                        free_d     = 1'b1;
                        free_idx_d = scan_q;
                    end
                    if (scan_q == LastIdx) begin
                        go_issue = 1'b1;
                        if (hit_d) begin
                            slot = hit_idx_d;
                        end else if (free_d) begin
                            slot = free_idx_d;
                        end else begin
                            slot    = steal_q;
                            steal_d = (steal_q == LastIdx) ? '0 : steal_q + IdxOne;
                        end
                    end
                end else if (rd_busy && key_match && (type_q == EV_KEYPRESS || !rd_rel)) begin
                    go_issue = 1'b1;
                    slot     = scan_q;
                end else if (scan_q == LastIdx) begin
                    drop_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (setup_q == SetupW'(ADDR_SETUP - 1)) state_d = StStrobe;
                else                                    setup_d = setup_q + SetupW'(1);
            end
            StStrobe: begin
                state_d = StHold;
                cm_en   = (type_q == EV_PRESS) || (type_q == EV_RELEASE);
            end
            StHold: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (go_issue) begin
            state_d = StIssue;
            setup_d = '0;
            addr_d  = slot;
            note_d  = ev_note_q;
            vel_d   = ev_vel_q;
            chan_d  = ev_ch_q;
        end
    end

    always_ff @(posedge clk96) begin
        if (rst) begin
            state_q    <= StIdle;
            type_q     <= EV_PRESS;
            ev_ch_q    <= '0;
            ev_note_q  <= '0;
            ev_vel_q   <= '0;
            scan_q     <= '0;
            steal_q    <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
            setup_q    <= '0;
            addr_q     <= '0;
            note_q     <= '0;
            vel_q      <= '0;
            chan_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            ev_ch_q    <= ev_ch_d;
            ev_note_q  <= ev_note_d;
            ev_vel_q   <= ev_vel_d;
            scan_q     <= scan_d;
            steal_q    <= steal_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            free_q     <= free_d;
            free_idx_q <= free_idx_d;
            setup_q    <= setup_d;
            addr_q     <= addr_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            chan_q     <= chan_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.ev_ready      = (state_q == StIdle);
    assign bus.note_pressed  = (state_q == StStrobe) && (type_q == EV_PRESS);
    assign bus.note_released = (state_q == StStrobe) && (type_q == EV_RELEASE);
    assign bus.note_keypress = (state_q == StStrobe) && (type_q == EV_KEYPRESS);
    assign bus.pitch_wheel   = (state_q == StStrobe) && (type_q == EV_WHEEL);
    assign bus.addr          = addr_q;
    assign bus.note          = note_q;
    assign bus.velocity      = vel_q;
    assign bus.channel       = chan_q;
    assign bus.drop          = drop_q;

endmodule
